// File: rtl/calc_display.sv
// Calculator result display: captures printed digits into a shadow frame,
// commits complete frames and time-multiplexes them onto an 8-digit display.
module calc_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_done,
  output logic       err
);

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_PRINT = 2'b11;
  localparam logic [15:0] WRAP    = 16'(SCAN_DIV - 1);

  logic [7:0][3:0] shadow_q, shadow_d;
  logic [7:0][3:0] disp_q, disp_d;
  logic [7:0]      valid_q, valid_d;
  logic            err_q, err_d;
  logic            fd_q, fd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [7:0]      an_q, an_d;

  logic       cap;
  logic       last;
  logic       commit;
  logic [2:0] slot;
  logic [2:0] msd;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] err_glyph(input logic [2:0] i);
    logic [6:0] g;
    case (i)
      3'd3:    g = 7'h06;
      3'd2:    g = 7'h2F;
      3'd1:    g = 7'h2F;
      3'd0:    g = 7'h23;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  always_comb begin
    cap    = (status == ST_PRINT) && (pos >= 4'd1) && (pos <= 4'd8);
    last   = cap && (pos == 4'd8);
    commit = last && (&valid_q[6:0]);
    slot   = pos[2:0] - 3'd1;
  end

  // Frame capture: shadow collects digits, display updates only on commit
  always_comb begin
    shadow_d = shadow_q;
    valid_d  = valid_q;
    disp_d   = disp_q;
    err_d    = err_q;
    fd_d     = 1'b0;
    if (cap) begin
      shadow_d[slot] = data;
      valid_d[slot]  = 1'b1;
    end
    if (status != ST_PRINT || last) begin
      valid_d = '0;
    end
    if (commit) begin
      disp_d = shadow_d;
      err_d  = 1'b0;
      fd_d   = 1'b1;
    end
    if (status == ST_ERR) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    msd = '0;
    for (int i = 1; i < 8; i++) begin
      if (disp_q[i] != 4'd0) msd = 3'(i);
    end
  end

  always_comb begin
    cnt_d = (cnt_q == WRAP) ? '0 : cnt_q + 16'd1;
    idx_d = (cnt_q == WRAP) ? idx_q + 3'd1 : idx_q;
    an_d  = ~(8'd1 << idx_q);
    if (err_q) begin
      seg_d = err_glyph(idx_q);
    end else if (idx_q > msd) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = glyph(disp_q[idx_q]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      disp_q   <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
      fd_q     <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 8'hFF;
    end else begin
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      fd_q     <= fd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: doc/calc_display.md
CALC_DISPLAY -- requirements
Module: calc_display

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clock cycles each digit stays lit before the scan advances (legal range 1..65535).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 status  input  2  calculator status: 00 error, 01 busy, 10 ready, 11 printing.
REQ-005 data  input  4  digit value (0..9) offered by the calculator during printing.
REQ-006 pos  input  4  digit slot of data: 1 = least significant, 8 = most significant, 0 = no digit.
REQ-007 seg  output  7  active-low segments {g,f,e,d,c,b,a} for the lit digit; registered.
REQ-008 an  output  8  active-low one-hot anode enable; an[0] = rightmost (units) digit; registered.
REQ-009 frame_done  output  1  one-cycle pulse when a complete 8-digit frame is committed.
REQ-010 err  output  1  high while error mode is active.

Function
REQ-011 The block SHALL sample status, data and pos on every rising clock edge; a capture occurs when status==11 and pos is in 1..8.
REQ-012 On a capture, the block SHALL write data into shadow[pos-1] and set valid[pos-1].
REQ-013 When status!=11, the block SHALL clear valid[7:0]; a partial frame is discarded and the display buffer is unchanged.
REQ-014 A capture with pos==8 while valid[6:0] are all set SHALL copy shadow (including the pos-8 digit) to the display buffer, pulse frame_done for exactly one cycle, clear valid, and clear err.
REQ-015 A capture with pos==8 while any of valid[6:0] is clear SHALL discard the frame: no commit, no pulse, valid cleared.
REQ-016 A capture repeating an already-valid slot SHALL overwrite that slot; valid is unchanged.
REQ-017 Sampling status==00 SHALL set err on the next edge; err SHALL hold until the next commit or reset.
REQ-018 Scan: a counter SHALL count 0..SCAN_DIV-1; on its wrap, the 3-bit index SHALL advance 0->1->...->7->0.
REQ-019 Each edge, an SHALL be set to ~(1<<index) and seg to the decoded glyph for index, both using values from the previous edge, giving exactly one cycle of output latency.
REQ-020 Glyphs (hex, gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F, E=06, r=2F, o=23.
REQ-021 Normal mode: digit values 10..15 SHALL display blank.
REQ-022 Normal mode: leading-zero blanking; digits above the most significant nonzero digit SHALL be blank; digit 0 SHALL always be shown, even when zero.
REQ-023 Error mode: digits 3..0 SHALL show E, r, r, o and digits 7..4 blank; the display buffer is retained and reappears only after a new commit.
REQ-024 Simultaneous events: if status is 00 while a commit is pending, no commit occurs, because status is not 11.
REQ-025 The block SHALL never stall the calculator and has no backpressure; every edge's input is consumed or ignored.

Reset
REQ-026 While reset is high: seg=7F, an=FF, frame_done=0, err=0, scan counter=0, index=0, valid=0, shadow=0, display buffer all 0.
REQ-027 After reset release, scanning SHALL begin on the first edge; the display shows "0" on digit 0 and blanks elsewhere.
REQ-028 Reset asserted mid-frame or mid-scan SHALL discard all progress immediately, without waiting for a clock edge.

Verification (bench SCAN_DIV=2)
REQ-029 Reset, then 16 idle cycles -> an steps FE, FD, ..., 7F every 2 cycles; seg=40 only when an=FE, otherwise 7F.
REQ-030 Status 11 with pos 1..8 and data 7,3,1,0,0,0,0,0 -> one frame_done pulse the cycle after pos=8; display shows 137; digit 0 seg=78, digit 1=30, digit 2=79, digits 3..7=7F.
REQ-031 Frame with pos 1..5, then status 10 for one cycle, then pos 6..8 -> no frame_done; previous display retained.
REQ-032 Status 00 for one cycle after a committed frame -> err=1; digits 3..0 show 06, 2F, 2F, 23; a following full frame of 5,0,...,0 -> err=0 and digit 0 shows 12.
REQ-033 Assert reset at pos=4 of a frame, release, then send a full frame of 9 in all slots -> exactly one frame_done; all eight digits show 10.
